ksa_sub_pipe: RTL

Pipelined Kogge-Stone subtractor, the difference-side counterpart of the 8-bit Kogge-Stone adder. Computes `a - b - bin` with borrow-out and signed-overflow flags. Uses a two-stage valid/ready pipeline so it can sit between streaming producers and consumers in the datapath. Reuses the adder's parallel-prefix carry network on inverted operands.

---
 rtl/ksa_pkg.sv | 33 +++
 rtl/ksa_prefix_tree.sv | 40 ++++
 rtl/ksa_sub_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ksa_pkg
// Brief    : Shared constants, stage payload type and level-count helper for
//            the Kogge-Stone adder/subtractor family.
// Revision : 1.0
// ============================================================================
package ksa_pkg;

    localparam int KSA_WIDTH_DEFAULT = 8;

    // S1 payload at the default width; wider instances use a same-shaped local type.
    typedef struct packed {
        logic [KSA_WIDTH_DEFAULT-1:0] g;
        logic [KSA_WIDTH_DEFAULT-1:0] p;
        logic                         cin;
        logic                         a_msb;
        logic                         b_msb;
    } ksa_s1_t;

    function automatic int ksa_levels(input int width);
        int lv;
        lv = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < width) begin
                lv = i + 1;
            end
        end
        return lv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ksa_prefix_tree.sv
`default_nettype none
// ============================================================================
// Module   : ksa_prefix_tree
// Brief    : Combinational Kogge-Stone carry network; carry-in is folded into
//            bit 0 so carry[i] is the carry into bit i.
// Revision : 1.0
// ============================================================================
module ksa_prefix_tree
    import ksa_pkg::*;
#(
    parameter int WIDTH = KSA_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             cin,
    output logic [WIDTH-1:0] carry,
    output logic             cout
);

    localparam int c_levels = ksa_levels(WIDTH);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;

    // Each pass doubles the span of every group; low positions whose span has
    // already reached bit 0 see a zero-filled shift and keep their final value.
    always_comb begin
        w_g = {g[WIDTH-1:1], g[0] | (p[0] & cin)};
        w_p = p;
        for (int l = 0; l < c_levels; l++) begin
            w_g = w_g | (w_p & (w_g << (1 << l)));
            w_p = w_p & (w_p << (1 << l));
        end
    end

    assign carry = {w_g[WIDTH-2:0], cin};
    assign cout  = w_g[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/ksa_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ksa_sub_pipe
// Brief    : Two-stage valid/ready pipelined Kogge-Stone subtractor computing
//            a - b - bin with borrow-out and signed-overflow flags.
// Revision : 1.0
// ============================================================================
module ksa_sub_pipe
    import ksa_pkg::*;
#(
    parameter int WIDTH = KSA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int c_msb = WIDTH - 1;

    generate
        if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $error("ksa_sub_pipe: WIDTH must be a power of two >= 2");
        end
    endgenerate

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             cin;
        logic             a_msb;
        logic             b_msb;
    } s1_t;

    s1_t              r_s1;
    logic             r_s1_valid;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;

    logic [WIDTH-1:0] w_nb;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_d;
    logic             w_cout;
    logic             w_s2_load;
    logic             w_ovf;

    assign w_nb      = ~b;
    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;

    // Stage 1: generate/propagate of a + ~b, carry-in = !bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1.g     <= a & w_nb;
                r_s1.p     <= a ^ w_nb;
                r_s1.cin   <= ~bin;
                r_s1.a_msb <= a[c_msb];
                r_s1.b_msb <= b[c_msb];
            end
        end
    end

    ksa_prefix_tree #(
        .WIDTH (WIDTH)
    ) u_prefix_tree (
        .g     (r_s1.g),
        .p     (r_s1.p),
        .cin   (r_s1.cin),
        .carry (w_carry),
        .cout  (w_cout)
    );

    assign w_d   = r_s1.p ^ w_carry;
    assign w_ovf = (r_s1.a_msb ^ r_s1.b_msb) & (w_d[c_msb] ^ r_s1.a_msb);

    // Stage 2: result beat, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            r_out_valid <= r_s1_valid;
            if (w_s2_load) begin
                r_d    <= w_d;
                r_bout <= ~w_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign d         = r_d;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
